// File: rtl/fb_pkg.sv
// Shared constants, FSM encoding and address helpers for the framebuffer port arbiter.
package fb_pkg;

    localparam int unsigned FB_W    = 128;
    localparam int unsigned FB_H    = 96;
    localparam int unsigned PIX_W   = 12;
    localparam int unsigned COORD_W = 7;
    localparam int unsigned ADDR_W  = 14;

    localparam logic [COORD_W-1:0] OOB_ADDR = COORD_W'(7'h7F);
    localparam logic [PIX_W-1:0]   BLANK    = '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WR       = 2'd3
    } fb_state_e;

    // Linear BRAM address; only meaningful for in-range coordinates, so it cannot overflow.
    function automatic logic [ADDR_W-1:0] compose_addr(input logic [COORD_W-1:0] x,
                                                       input logic [COORD_W-1:0] y);
        return ADDR_W'(ADDR_W'(y) * ADDR_W'(FB_W)) + ADDR_W'(x);
    endfunction

    // The 7'h7F marker is out of bounds even where it would fit the framebuffer.
    function automatic logic coord_in_range(input logic [COORD_W-1:0] x,
                                            input logic [COORD_W-1:0] y);
        return (x != OOB_ADDR) && (y != OOB_ADDR) &&
               (32'(x) < FB_W) && (32'(y) < FB_H);
    endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Write-client handshake plus the single BRAM port owned by the arbiter.
interface fb_port_arbiter_if;

    logic                            wr_req;
    logic [fb_pkg::COORD_W-1:0]      wr_x;
    logic [fb_pkg::COORD_W-1:0]      wr_y;
    logic [fb_pkg::PIX_W-1:0]        wr_data;
    logic                            wr_ack;
    logic                            wr_err;

    logic                            bram_en;
    logic                            bram_we;
    logic [fb_pkg::ADDR_W-1:0]       bram_addr;
    logic [fb_pkg::PIX_W-1:0]        bram_wdata;
    logic [fb_pkg::PIX_W-1:0]        bram_rdata;

    // Environment side: the drawing engine and the BRAM itself.
    modport master (
        output wr_req, wr_x, wr_y, wr_data, bram_rdata,
        input  wr_ack, wr_err, bram_en, bram_we, bram_addr, bram_wdata
    );

    // Arbiter side.
    modport slave (
        input  wr_req, wr_x, wr_y, wr_data, bram_rdata,
        output wr_ack, wr_err, bram_en, bram_we, bram_addr, bram_wdata
    );

endinterface

// File: rtl/fb_addr_compose.sv
// Combinational range check and linear address for one coordinate pair.
module fb_addr_compose
    import fb_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               in_range_c,
    output logic [ADDR_W-1:0]  addr_c
);

    assign in_range_c = coord_in_range(x, y);
    assign addr_c     = compose_addr(x, y);

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares the framebuffer BRAM port: display fetches win, writes fill the idle slots.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned BRAM_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               disp_active,
    input  logic [COORD_W-1:0] disp_x,
    input  logic [COORD_W-1:0] disp_y,
    output logic [PIX_W-1:0]   disp_pixel,
    output logic               disp_valid,
    fb_port_arbiter_if.slave   bus
);

    localparam int unsigned WAIT_W = 2;

    fb_state_e          state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [COORD_W-1:0] last_x_q, last_x_d, last_y_q, last_y_d;
    logic               pend_q, pend_d;
    logic               stale_q, stale_d;
    logic [PIX_W-1:0]   pix_d;
    logic               valid_d;
    logic               bram_en_d, bram_we_d, wr_ack_d, wr_err_d;
    logic [ADDR_W-1:0]  bram_addr_d;
    logic [PIX_W-1:0]   bram_wdata_d;

    logic               disp_in_range, wr_in_range;
    logic [ADDR_W-1:0]  disp_addr, wr_addr;
    logic               trig, rd_go, read_done, in_flight, arb;

    fb_addr_compose u_disp_addr (
        .x          (disp_x),
        .y          (disp_y),
        .in_range_c (disp_in_range),
        .addr_c     (disp_addr)
    );

    fb_addr_compose u_wr_addr (
        .x          (bus.wr_x),
        .y          (bus.wr_y),
        .in_range_c (wr_in_range),
        .addr_c     (wr_addr)
    );

    assign trig      = disp_active && ({disp_x, disp_y} != {last_x_q, last_y_q});
    assign rd_go     = disp_active && disp_in_range && (pend_q || trig);
    assign read_done = (state_q == RD_WAIT) && (wait_cnt_q == WAIT_W'(BRAM_LAT - 1));
    // A read still outstanding after this cycle; its data becomes stale on a new coordinate.
    assign in_flight = ((state_q == RD_ISSUE) || (state_q == RD_WAIT)) && !read_done;
    // Port decisions are taken in IDLE and in the last read-wait cycle, whose port slot is free.
    assign arb       = (state_q == IDLE) || read_done;

    // Next-state, display tracking and next values of all registered outputs.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        last_x_d     = last_x_q;
        last_y_d     = last_y_q;
        pend_d       = pend_q;
        stale_d      = stale_q;
        pix_d        = disp_pixel;
        valid_d      = disp_valid;
        bram_en_d    = 1'b0;
        bram_we_d    = 1'b0;
        bram_addr_d  = '0;
        bram_wdata_d = '0;
        wr_ack_d     = 1'b0;
        wr_err_d     = 1'b0;

        case (state_q)
            IDLE: ;
            RD_ISSUE: begin
                state_d    = RD_WAIT;
                wait_cnt_d = '0;
            end
            RD_WAIT: begin
                if (!read_done) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (read_done) begin
            stale_d = 1'b0;
            if (!stale_q) begin
                pix_d   = bus.bram_rdata;
                valid_d = 1'b1;
            end
        end

        if (!disp_active) begin
            pix_d    = BLANK;
            valid_d  = 1'b0;
            last_x_d = OOB_ADDR;
            last_y_d = OOB_ADDR;
            pend_d   = 1'b0;
            stale_d  = in_flight;
        end else if (trig) begin
            stale_d = in_flight;
            if (!disp_in_range) begin
                pix_d    = BLANK;
                valid_d  = 1'b1;
                last_x_d = disp_x;
                last_y_d = disp_y;
                pend_d   = 1'b0;
            end else begin
                valid_d = 1'b0;
                pend_d  = 1'b1;
            end
        end

        if (arb) begin
            state_d = IDLE;
            if (rd_go) begin
                state_d     = RD_ISSUE;
                bram_en_d   = 1'b1;
                bram_addr_d = disp_addr;
                last_x_d    = disp_x;
                last_y_d    = disp_y;
                pend_d      = 1'b0;
            end else if (bus.wr_req) begin
                state_d  = WR;
                wr_ack_d = 1'b1;
                if (wr_in_range) begin
                    bram_en_d    = 1'b1;
                    bram_we_d    = 1'b1;
                    bram_addr_d  = wr_addr;
                    bram_wdata_d = bus.wr_data;
                end else begin
                    wr_err_d = 1'b1;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Display tracking registers and registered port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q     <= '0;
            last_x_q       <= OOB_ADDR;
            last_y_q       <= OOB_ADDR;
            pend_q         <= 1'b0;
            stale_q        <= 1'b0;
            disp_pixel     <= BLANK;
            disp_valid     <= 1'b0;
            bus.bram_en    <= 1'b0;
            bus.bram_we    <= 1'b0;
            bus.bram_addr  <= '0;
            bus.bram_wdata <= '0;
            bus.wr_ack     <= 1'b0;
            bus.wr_err     <= 1'b0;
        end else begin
            wait_cnt_q     <= wait_cnt_d;
            last_x_q       <= last_x_d;
            last_y_q       <= last_y_d;
            pend_q         <= pend_d;
            stale_q        <= stale_d;
            disp_pixel     <= pix_d;
            disp_valid     <= valid_d;
            bus.bram_en    <= bram_en_d;
            bus.bram_we    <= bram_we_d;
            bus.bram_addr  <= bram_addr_d;
            bus.bram_wdata <= bram_wdata_d;
            bus.wr_ack     <= wr_ack_d;
            bus.wr_err     <= wr_err_d;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: vector table, BRAM port scoreboard, corner sequences.
module tb_fb_port_arbiter;
    import fb_pkg::*;

    localparam int unsigned BRAM_LAT = 1;
    localparam int unsigned ACC_LAT  = 2 + BRAM_LAT;

    typedef struct {
        bit          is_wr;
        logic [6:0]  x;
        logic [6:0]  y;
        logic [11:0] data;
        bit          acc;
        logic [13:0] addr;
        logic [11:0] pix;
        bit          err;
    } vec_t;

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [11:0] wdata;
        int          cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        disp_active = 1'b0;
    logic [6:0]  disp_x = '0;
    logic [6:0]  disp_y = '0;
    logic [11:0] disp_pixel;
    logic        disp_valid;

    fb_port_arbiter_if bus ();

    fb_port_arbiter #(.BRAM_LAT(BRAM_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .disp_active (disp_active),
        .disp_x      (disp_x),
        .disp_y      (disp_y),
        .disp_pixel  (disp_pixel),
        .disp_valid  (disp_valid),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // BRAM model: read data equals the address, BRAM_LAT cycles after a read enable.
    logic [11:0] rd_pipe [BRAM_LAT];
    always @(posedge clk) begin
        if (bus.bram_en && !bus.bram_we) rd_pipe[0] <= 12'(bus.bram_addr);
        for (int i = 1; i < BRAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.bram_rdata = rd_pipe[BRAM_LAT-1];

    sb_t  sb_q [$];
    vec_t vecs [10];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare every BRAM access against the scoreboard, including its cycle.
    task automatic check_port();
        sb_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL sb_missed: got no access expected addr %0d we %0d at cycle %0d", e.addr, e.we, e.cyc);
        end
        if (bus.bram_en) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got access addr %0d we %0d expected none (cycle %0d)",
                         bus.bram_addr, bus.bram_we, cyc);
            end else begin
                e = sb_q.pop_front();
                check("sb_access", {bus.bram_we, bus.bram_addr, 32'(cyc)}, {e.we, e.addr, 32'(e.cyc)});
                if (e.we) check("sb_wdata", bus.bram_wdata, e.wdata);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_port();
    endtask

    task automatic do_disp(input vec_t v);
        int c0;
        c0 = cyc;
        disp_x = v.x;
        disp_y = v.y;
        if (v.acc) begin
            sb_q.push_back('{1'b0, v.addr, 12'h0, c0 + 1});
            tick();
            check("disp_valid_drop", disp_valid, 1'b0);
            for (int k = 2; k <= int'(ACC_LAT); k++) tick();
            check("disp_pixel", disp_pixel, v.pix);
            check("disp_valid", disp_valid, 1'b1);
        end else begin
            tick();
            check("oob_pixel", disp_pixel, BLANK);
            check("oob_valid", disp_valid, 1'b1);
            tick();
            tick();
        end
    endtask

    task automatic do_wr(input vec_t v, input int exp_lat);
        int   c0;
        int   got;
        logic err_at_ack;
        c0  = cyc;
        got = 0;
        bus.wr_req  = 1'b1;
        bus.wr_x    = v.x;
        bus.wr_y    = v.y;
        bus.wr_data = v.data;
        if (v.acc) sb_q.push_back('{1'b1, v.addr, v.data, c0 + exp_lat});
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (bus.wr_ack) begin
                got = k;
                break;
            end
        end
        err_at_ack = bus.wr_err;
        bus.wr_req = 1'b0;
        check("wr_ack_lat", 32'(got), 32'(exp_lat));
        check("wr_err", err_at_ack, v.err);
        tick();
        check("wr_ack_pulse", bus.wr_ack, 1'b0);
    endtask

    initial begin
        int c0;
        int got;

        vecs[0] = '{1'b0, 7'd3,   7'd2,   12'h000, 1'b1, 14'd259,   12'd259,  1'b0};
        vecs[1] = '{1'b1, 7'd10,  7'd5,   12'hABC, 1'b1, 14'd650,   12'h000,  1'b0};
        vecs[2] = '{1'b0, 7'h7F,  7'd2,   12'h000, 1'b0, 14'd0,     BLANK,    1'b0};
        vecs[3] = '{1'b0, 7'd5,   7'd95,  12'h000, 1'b1, 14'd12165, 12'hF85,  1'b0};
        vecs[4] = '{1'b0, 7'd10,  7'd96,  12'h000, 1'b0, 14'd0,     BLANK,    1'b0};
        vecs[5] = '{1'b1, 7'h7F,  7'd5,   12'h111, 1'b0, 14'd0,     12'h000,  1'b1};
        vecs[6] = '{1'b1, 7'd5,   7'd100, 12'h222, 1'b0, 14'd0,     12'h000,  1'b1};
        vecs[7] = '{1'b0, 7'd126, 7'd95,  12'h000, 1'b1, 14'd12286, 12'hFFE,  1'b0};
        vecs[8] = '{1'b1, 7'd126, 7'd95,  12'h5A5, 1'b1, 14'd12286, 12'h000,  1'b0};
        vecs[9] = '{1'b1, 7'd0,   7'd0,   12'h123, 1'b1, 14'd0,     12'h000,  1'b0};

        bus.wr_req  = 1'b0;
        bus.wr_x    = '0;
        bus.wr_y    = '0;
        bus.wr_data = '0;

        // Reset state.
        tick();
        tick();
        check("reset_outputs",
              {disp_pixel, disp_valid, bus.bram_en, bus.bram_we, bus.bram_addr,
               bus.bram_wdata, bus.wr_ack, bus.wr_err}, 64'd0);
        reset       = 1'b0;
        disp_active = 1'b1;

        // Vector table: display fetches, out-of-bounds coordinates and writes.
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) do_wr(vecs[i], 1);
            else               do_disp(vecs[i]);
        end

        // Write and coordinate change together: read first, ack BRAM_LAT+2 cycles later.
        c0  = cyc;
        got = 0;
        disp_x = 7'd3;
        disp_y = 7'd4;
        bus.wr_req  = 1'b1;
        bus.wr_x    = 7'd8;
        bus.wr_y    = 7'd8;
        bus.wr_data = 12'h3C3;
        sb_q.push_back('{1'b0, 14'd515, 12'h000, c0 + 1});
        sb_q.push_back('{1'b1, 14'd1032, 12'h3C3, c0 + int'(BRAM_LAT) + 2});
        for (int k = 1; k <= int'(ACC_LAT) + 3; k++) begin
            tick();
            if (k == int'(ACC_LAT)) begin
                check("both_pixel", disp_pixel, 12'd515);
                check("both_valid", disp_valid, 1'b1);
            end
            if (bus.wr_ack && got == 0) begin
                got = k;
                bus.wr_req = 1'b0;
            end
        end
        bus.wr_req = 1'b0;
        check("both_ack_lat", 32'(got), 32'(BRAM_LAT + 2));

        // Coordinate change while a write is on the port costs one extra cycle.
        c0 = cyc;
        bus.wr_req  = 1'b1;
        bus.wr_x    = 7'd1;
        bus.wr_y    = 7'd1;
        bus.wr_data = 12'h0F0;
        sb_q.push_back('{1'b1, 14'd129, 12'h0F0, c0 + 1});
        tick();
        check("busy_ack", bus.wr_ack, 1'b1);
        bus.wr_req = 1'b0;
        disp_x = 7'd20;
        disp_y = 7'd3;
        c0 = cyc;
        sb_q.push_back('{1'b0, 14'd404, 12'h000, c0 + 2});
        for (int k = 1; k <= int'(ACC_LAT); k++) tick();
        check("busy_valid_early", disp_valid, 1'b0);
        tick();
        check("busy_pixel", disp_pixel, 12'd404);
        check("busy_valid", disp_valid, 1'b1);

        // Inactive blanks the output and forces a re-fetch of the same coordinate.
        disp_active = 1'b0;
        tick();
        check("inactive_out", {disp_pixel, disp_valid}, {BLANK, 1'b0});
        disp_active = 1'b1;
        sb_q.push_back('{1'b0, 14'd404, 12'h000, cyc + 1});
        for (int k = 1; k <= int'(ACC_LAT); k++) tick();
        check("refetch_pixel", {disp_pixel, disp_valid}, {12'd404, 1'b1});

        // Reset while a read is waiting for BRAM data.
        disp_x = 7'd7;
        disp_y = 7'd1;
        sb_q.push_back('{1'b0, 14'd135, 12'h000, cyc + 1});
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check("async_reset",
              {disp_pixel, disp_valid, bus.bram_en, bus.bram_we, bus.bram_addr,
               bus.bram_wdata, bus.wr_ack, bus.wr_err}, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        sb_q.push_back('{1'b0, 14'd135, 12'h000, cyc + 1});
        for (int k = 1; k <= int'(ACC_LAT); k++) tick();
        check("post_reset_pixel", {disp_pixel, disp_valid}, {12'd135, 1'b1});

        tick();
        tick();
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
